// File: rtl/smbus_slave_axis.sv
// SMBus target bridging master writes to an AXI-Stream output and serving master reads from an
// AXI-Stream input. SDA is open-drain; SCL is only observed, never stretched.
module smbus_slave_axis #(
   parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
   parameter int unsigned HOLD_CYCLES = 30
) (
   input  logic       ap_clk,
   input  logic       ap_rst_n,
   input  logic       quiesce,
   input  logic       smb_sclk,
   inout  wire        smb_sdata,
   output logic [7:0] to_host_smb_tdata,
   output logic       to_host_smb_tvalid,
   input  logic       to_host_smb_tready,
   output logic       to_host_smb_tuser,
   input  logic [7:0] from_host_smb_tdata,
   input  logic       from_host_smb_tvalid,
   output logic       from_host_smb_tready,
   output logic       rx_overflow,
   output logic       tx_underrun
);

   localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StWaitStop
   } state_e;

   state_e          state_q;
   logic [1:0]      scl_sync_q, sda_sync_q;
   logic            scl_prev_q, sda_prev_q;
   logic            scl, sda, scl_rise, scl_fall, start_det, stop_det, hold_done;
   logic [2:0]      bit_cnt_q;
   logic [7:0]      shift_q, tx_q, tx_next;
   logic            rw_q, sda_oe_q, pend_q, byte_done_q, ack_drv_q, ack_ok_q, first_q;
   logic [CntW-1:0] hold_cnt_q;

   assign smb_sdata = sda_oe_q ? 1'b0 : 1'bz;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], smb_sclk};
         sda_sync_q <= {sda_sync_q[0], smb_sdata};
         scl_prev_q <= scl_sync_q[1];
         sda_prev_q <= sda_sync_q[1];
      end
   end

   assign scl       = scl_sync_q[1];
   assign sda       = sda_sync_q[1];
   assign scl_rise  = scl & ~scl_prev_q;
   assign scl_fall  = ~scl & scl_prev_q;
   assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
   assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
   assign hold_done = pend_q && (hold_cnt_q == '0);
   assign tx_next   = from_host_smb_tvalid ? from_host_smb_tdata : 8'hFF;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q              <= StIdle;
         bit_cnt_q            <= 3'd0;
         shift_q              <= 8'h00;
         tx_q                 <= 8'h00;
         rw_q                 <= 1'b0;
         sda_oe_q             <= 1'b0;
         pend_q               <= 1'b0;
         hold_cnt_q           <= '0;
         byte_done_q          <= 1'b0;
         ack_drv_q            <= 1'b0;
         ack_ok_q             <= 1'b0;
         first_q              <= 1'b0;
         to_host_smb_tdata    <= 8'h00;
         to_host_smb_tvalid   <= 1'b0;
         to_host_smb_tuser    <= 1'b0;
         from_host_smb_tready <= 1'b0;
         rx_overflow          <= 1'b0;
         tx_underrun          <= 1'b0;
      end else begin
         from_host_smb_tready <= 1'b0;
         rx_overflow          <= 1'b0;
         tx_underrun          <= 1'b0;
         if (to_host_smb_tvalid && to_host_smb_tready) to_host_smb_tvalid <= 1'b0;
         if (pend_q && hold_cnt_q != '0) hold_cnt_q <= hold_cnt_q - 1'b1;
         if (hold_done) pend_q <= 1'b0;

         if (quiesce) begin
            state_q            <= StIdle;
            sda_oe_q           <= 1'b0;
            pend_q             <= 1'b0;
            to_host_smb_tvalid <= 1'b0;
         end else if (start_det || stop_det) begin
            // A bus condition cancels any pending SDA update and restarts framing.
            state_q     <= start_det ? StAddr : StIdle;
            bit_cnt_q   <= 3'd7;
            sda_oe_q    <= 1'b0;
            pend_q      <= 1'b0;
            byte_done_q <= 1'b0;
            ack_drv_q   <= 1'b0;
            ack_ok_q    <= 1'b0;
            if (start_det) first_q <= 1'b1;
         end else begin
            unique case (state_q)
               StIdle, StWaitStop: begin
               end
               StAddr: begin
                  if (scl_rise && !byte_done_q) begin
                     shift_q <= {shift_q[6:0], sda};
                     if (bit_cnt_q == 3'd0) byte_done_q <= 1'b1;
                     else bit_cnt_q <= bit_cnt_q - 3'd1;
                  end
                  if (scl_fall && byte_done_q && !pend_q) begin
                     pend_q     <= 1'b1;
                     hold_cnt_q <= HoldLoad;
                  end
                  if (hold_done) begin
                     byte_done_q <= 1'b0;
                     if (shift_q[7:1] == SLAVE_ADDR) begin
                        sda_oe_q <= 1'b1;
                        rw_q     <= shift_q[0];
                        state_q  <= StAddrAck;
                     end else begin
                        state_q <= StWaitStop;
                     end
                  end
               end
               StAddrAck: begin
                  if (scl_fall && !pend_q) begin
                     pend_q     <= 1'b1;
                     hold_cnt_q <= HoldLoad;
                     if (rw_q) begin
                        tx_q                 <= tx_next;
                        from_host_smb_tready <= from_host_smb_tvalid;
                        tx_underrun          <= ~from_host_smb_tvalid;
                     end
                  end
                  if (hold_done) begin
                     bit_cnt_q <= 3'd7;
                     sda_oe_q  <= rw_q ? ~tx_q[7] : 1'b0;
                     state_q   <= rw_q ? StTx : StRx;
                  end
               end
               StRx: begin
                  if (scl_rise) begin
                     shift_q <= {shift_q[6:0], sda};
                     if (bit_cnt_q == 3'd0) begin
                        state_q   <= StRxAck;
                        ack_drv_q <= 1'b0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                     end
                  end
               end
               StRxAck: begin
                  // First fall: decide ACK/NACK; second fall: release and resume receiving.
                  if (scl_fall && !pend_q) begin
                     pend_q     <= 1'b1;
                     hold_cnt_q <= HoldLoad;
                     if (!ack_drv_q) begin
                        ack_ok_q <= ~to_host_smb_tvalid;
                        if (!to_host_smb_tvalid) begin
                           to_host_smb_tdata  <= shift_q;
                           to_host_smb_tvalid <= 1'b1;
                           to_host_smb_tuser  <= first_q;
                           first_q            <= 1'b0;
                        end else begin
                           rx_overflow <= 1'b1;
                        end
                     end
                  end
                  if (hold_done) begin
                     if (!ack_drv_q) begin
                        sda_oe_q  <= ack_ok_q;
                        ack_drv_q <= 1'b1;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 3'd7;
                        state_q   <= StRx;
                     end
                  end
               end
               StTx: begin
                  if (scl_fall && !pend_q) begin
                     pend_q     <= 1'b1;
                     hold_cnt_q <= HoldLoad;
                  end
                  if (hold_done) begin
                     if (bit_cnt_q == 3'd0) begin
                        sda_oe_q <= 1'b0;
                        ack_ok_q <= 1'b0;
                        state_q  <= StTxAck;
                     end else begin
                        bit_cnt_q <= bit_cnt_q - 3'd1;
                        sda_oe_q  <= ~tx_q[6];
                        tx_q      <= {tx_q[6:0], 1'b0};
                     end
                  end
               end
               StTxAck: begin
                  if (scl_rise && !ack_ok_q) begin
                     if (sda) state_q <= StWaitStop;
                     else ack_ok_q <= 1'b1;
                  end
                  if (scl_fall && ack_ok_q && !pend_q) begin
                     pend_q               <= 1'b1;
                     hold_cnt_q           <= HoldLoad;
                     tx_q                 <= tx_next;
                     from_host_smb_tready <= from_host_smb_tvalid;
                     tx_underrun          <= ~from_host_smb_tvalid;
                  end
                  if (hold_done) begin
                     ack_ok_q  <= 1'b0;
                     sda_oe_q  <= ~tx_q[7];
                     bit_cnt_q <= 3'd7;
                     state_q   <= StTx;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_smbus_slave_axis.sv
// Bench for smbus_slave_axis: a timed SMBus master plus AXI-Stream host models, checked against
// a transaction-level model of holding-register occupancy and read-byte sourcing.
module tb_smbus_slave_axis;

   localparam logic [6:0]  SLV  = 7'h50;
   localparam int unsigned HOLD = 10;
   localparam int          HALF = 24;
   localparam int          QTR  = HALF / 2;

   logic       ap_clk               = 1'b0;
   logic       ap_rst_n             = 1'b0;
   logic       quiesce              = 1'b0;
   logic       smb_sclk             = 1'b1;
   logic       m_sda_low            = 1'b0;
   logic       to_host_smb_tready   = 1'b0;
   logic       from_host_smb_tvalid = 1'b0;
   wire        smb_sdata;
   logic [7:0] to_host_smb_tdata;
   logic       to_host_smb_tvalid, to_host_smb_tuser;
   logic [7:0] from_host_smb_tdata;
   logic       from_host_smb_tready, rx_overflow, tx_underrun;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ovf_seen = 0, und_seen = 0, rdy_seen = 0, drive_seen = 0;
   int         rd_base = 0;
   bit         hold_full = 0;
   bit         first_flag = 0;
   logic [8:0] exp_q[$];
   logic [7:0] rd_list[8];
   logic [7:0] wr_buf[4];
   logic [8:0] prev_word = '0;
   bit         prev_hold = 0;
   logic [6:0] addr;
   logic       seen;

   assign smb_sdata = m_sda_low ? 1'b0 : 1'bz;
   pullup (smb_sdata);
   // Host read source advances by one entry per consumed byte.
   assign from_host_smb_tdata = rd_list[3'(rdy_seen - rd_base)];

   always #5 ap_clk = ~ap_clk;

   smbus_slave_axis #(
      .SLAVE_ADDR (SLV),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .ap_clk              (ap_clk),
      .ap_rst_n            (ap_rst_n),
      .quiesce             (quiesce),
      .smb_sclk            (smb_sclk),
      .smb_sdata           (smb_sdata),
      .to_host_smb_tdata   (to_host_smb_tdata),
      .to_host_smb_tvalid  (to_host_smb_tvalid),
      .to_host_smb_tready  (to_host_smb_tready),
      .to_host_smb_tuser   (to_host_smb_tuser),
      .from_host_smb_tdata (from_host_smb_tdata),
      .from_host_smb_tvalid(from_host_smb_tvalid),
      .from_host_smb_tready(from_host_smb_tready),
      .rx_overflow         (rx_overflow),
      .tx_underrun         (tx_underrun)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge ap_clk) begin
      if (!ap_rst_n) begin
         prev_hold = 0;
      end else begin
         if (rx_overflow) ovf_seen++;
         if (tx_underrun) und_seen++;
         if (from_host_smb_tready) rdy_seen++;
         if (!m_sda_low && smb_sdata === 1'b0) drive_seen++;
         if (prev_hold && to_host_smb_tvalid)
            check_eq("rx_stable", {to_host_smb_tuser, to_host_smb_tdata}, prev_word);
         if (to_host_smb_tvalid && to_host_smb_tready) begin
            if (exp_q.size() == 0) check_eq("rx_extra", exp_q.size(), 1);
            else check_eq("rx_byte", {to_host_smb_tuser, to_host_smb_tdata}, exp_q.pop_front());
         end
         prev_hold = to_host_smb_tvalid && !to_host_smb_tready;
         prev_word = {to_host_smb_tuser, to_host_smb_tdata};
      end
   end

   task automatic clks(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      clks(QTR); m_sda_low = ~b;
      clks(QTR); smb_sclk = 1'b1;
      clks(QTR); s = smb_sdata;
      clks(QTR); smb_sclk = 1'b0;
   endtask

   task automatic bus_start();
      m_sda_low = 1'b0; smb_sclk = 1'b1;
      clks(HALF); m_sda_low = 1'b1;
      clks(HALF); smb_sclk = 1'b0;
   endtask

   task automatic bus_stop();
      clks(QTR); m_sda_low = 1'b1;
      clks(QTR); smb_sclk = 1'b1;
      clks(QTR); m_sda_low = 1'b0;
      clks(HALF);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
      bit_xfer(1'b1, s);
      acked = (s === 1'b0);
   endtask

   task automatic recv_byte(input logic master_ack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         b[i] = s;
      end
      bit_xfer(~master_ack, s);
   endtask

   task automatic do_write(input logic [6:0] a, input int n, input logic rdy);
      logic acked, exp_ack, match;
      int   ovf0, drv0, ovf_exp;
      match = (a == SLV);
      to_host_smb_tready = rdy;
      if (rdy) hold_full = 0;
      ovf0 = ovf_seen; drv0 = drive_seen; ovf_exp = 0;
      bus_start();
      first_flag = 1;
      send_byte({a, 1'b0}, acked);
      check_eq("addr_ack", acked, match);
      for (int i = 0; i < n; i++) begin
         exp_ack = match && !hold_full;
         if (exp_ack) begin
            exp_q.push_back({first_flag, wr_buf[i]});
            first_flag = 0;
            hold_full = !rdy;
         end else if (match) begin
            ovf_exp++;
         end
         send_byte(wr_buf[i], acked);
         check_eq("data_ack", acked, exp_ack);
      end
      bus_stop();
      check_eq("rx_overflow_cnt", ovf_seen - ovf0, ovf_exp);
      if (!match) check_eq("sda_untouched", drive_seen - drv0, 0);
   endtask

   task automatic do_read(input int n, input logic avail);
      logic       acked;
      logic [7:0] b;
      int         und0;
      rd_base = rdy_seen; und0 = und_seen;
      from_host_smb_tvalid = avail;
      bus_start();
      send_byte({SLV, 1'b1}, acked);
      check_eq("rd_addr_ack", acked, 1);
      for (int j = 0; j < n; j++) begin
         recv_byte(j < n - 1, b);
         check_eq("rd_byte", b, avail ? rd_list[j] : 8'hFF);
      end
      bus_stop();
      from_host_smb_tvalid = 1'b0;
      check_eq("tready_pulses", rdy_seen - rd_base, avail ? n : 0);
      check_eq("underruns", und_seen - und0, avail ? 0 : n);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rd_list[i] = 8'h00;
      for (int i = 0; i < 4; i++) wr_buf[i] = 8'h00;
      clks(4);
      check_eq("rst_outputs", {to_host_smb_tvalid, to_host_smb_tuser, to_host_smb_tdata,
                               from_host_smb_tready, rx_overflow, tx_underrun}, 0);
      check_eq("rst_sda", smb_sdata, 1);
      ap_rst_n = 1'b1;
      clks(10);

      wr_buf[0] = 8'h12; wr_buf[1] = 8'h34;
      do_write(SLV, 2, 1'b1);
      wr_buf[0] = 8'h77; wr_buf[1] = 8'h88;
      do_write(7'h51, 2, 1'b1);
      wr_buf[0] = 8'h55; wr_buf[1] = 8'h66;
      do_write(SLV, 2, 1'b0);
      check_eq("held_byte", {to_host_smb_tvalid, to_host_smb_tdata}, 9'h155);

      quiesce = 1'b1; clks(1); quiesce = 1'b0;
      check_eq("quiesce_tvalid", to_host_smb_tvalid, 0);
      if (exp_q.size() != 0) void'(exp_q.pop_back());
      hold_full = 0;

      rd_list[0] = 8'h3C; rd_list[1] = 8'h7E;
      do_read(2, 1'b1);
      do_read(1, 1'b0);

      // Reset while the target holds its address ACK low.
      to_host_smb_tready = 1'b1;
      bus_start();
      for (int i = 7; i >= 0; i--) bit_xfer(i == 0 ? 1'b0 : SLV[i-1], seen);
      clks(QTR); m_sda_low = 1'b0;
      clks(QTR); smb_sclk = 1'b1;
      clks(QTR / 2);
      check_eq("ack_driven", smb_sdata, 0);
      ap_rst_n = 1'b0; #1;
      check_eq("rst_sda_release", smb_sdata, 1);
      check_eq("rst_mid_outputs", {to_host_smb_tvalid, to_host_smb_tuser, to_host_smb_tdata,
                                   from_host_smb_tready, rx_overflow, tx_underrun}, 0);
      clks(3); ap_rst_n = 1'b1;
      clks(QTR); smb_sclk = 1'b0;
      bus_stop();
      wr_buf[0] = 8'hA5;
      do_write(SLV, 1, 1'b1);

      for (int t = 0; t < 12; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            addr = ($urandom_range(0, 4) == 0) ? 7'($urandom) : SLV;
            for (int i = 0; i < 4; i++) wr_buf[i] = 8'($urandom);
            do_write(addr, $urandom_range(1, 3), 1'($urandom_range(0, 1)));
         end else begin
            for (int i = 0; i < 8; i++) rd_list[i] = 8'($urandom);
            do_read($urandom_range(1, 3), 1'($urandom_range(0, 1)));
         end
      end

      to_host_smb_tready = 1'b1;
      clks(4);
      check_eq("rx_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/smbus_slave_axis.md
SMBUS_SLAVE_AXIS -- requirements
Module: smbus_slave_axis

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit target address this block answers to.
REQ-002 Parameter HOLD_CYCLES, default 30, ap_clk cycles between detected SCL fall and SDA update.
REQ-003 ap_clk  in  1  single clock; all logic on rising edge.
REQ-004 ap_rst_n  in  1  asynchronous active-low reset.
REQ-005 quiesce  in  1  synchronous abort; overrides all state updates in that cycle.
REQ-006 smb_sclk  in  1  bus clock from master, externally pulled up.
REQ-007 smb_sdata  inout  1  open-collector data; drive 0 or release (z) only.
REQ-008 to_host_smb_tdata  out  8  byte written by master.
REQ-009 to_host_smb_tvalid  out  1  byte valid; held until tready.
REQ-010 to_host_smb_tready  in  1  host accepts byte.
REQ-011 to_host_smb_tuser  out  1  1 = first data byte after START/repeated START.
REQ-012 from_host_smb_tdata  in  8  byte returned to master on read.
REQ-013 from_host_smb_tvalid  in  1  read byte available.
REQ-014 from_host_smb_tready  out  1  single-cycle pulse when read byte is consumed.
REQ-015 rx_overflow  out  1  one-cycle pulse: received byte NACKed, holding register full.
REQ-016 tx_underrun  out  1  one-cycle pulse: read byte requested, none available, 8'hFF sent.

Function
REQ-017 SCL and SDA shall pass through 2-flop synchronizers; all edge detection uses synchronized values; ap_clk >= 20x SCL rate.
REQ-018 START/repeated START = synced SDA falling while synced SCL high; from any state -> ADDR, bit count 7, SDA released.
REQ-019 STOP = synced SDA rising while synced SCL high; from any state -> IDLE, SDA released.
REQ-020 States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP.
REQ-021 Data bits shall be sampled MSB first on synced SCL rising edge.
REQ-022 ADDR: after 8th bit, on next SCL fall + HOLD_CYCLES: address[7:1]==SLAVE_ADDR -> drive SDA low, ADDR_ACK; mismatch -> WAIT_STOP, SDA released.
REQ-023 ACK low shall be held until next SCL fall; then after HOLD_CYCLES release SDA (write, -> RX) or drive TX bit 7 (read, -> TX).
REQ-024 Read entry: byte loaded at SCL fall ending ADDR_ACK; from_host_smb_tvalid=1 -> take tdata, pulse tready one cycle; else load 8'hFF, pulse tx_underrun.
REQ-025 TX: each bit changes HOLD_CYCLES after SCL fall; after bit 0, SDA released, -> TX_ACK.
REQ-026 TX_ACK: master SDA sampled at SCL rise; 0 -> load next byte per REQ-024, TX; 1 (NACK) -> WAIT_STOP.
REQ-027 RX: after 8th bit -> RX_ACK; at next SCL fall, holding register empty -> load byte, assert to_host tvalid, ACK; full -> NACK (SDA released), pulse rx_overflow, byte dropped, remain in RX sequence.
REQ-028 to_host tvalid deasserts the cycle after tvalid&&tready; tdata/tuser stable while tvalid.
REQ-029 tuser set for first byte loaded after START, cleared for subsequent bytes.
REQ-030 Block shall never drive SCL (no clock stretching).
REQ-031 WAIT_STOP ignores data bits; leaves only on START or STOP.
REQ-032 START/STOP detected during a HOLD_CYCLES countdown cancels the pending SDA update.
REQ-033 quiesce: state IDLE, SDA released, holding register emptied, tvalid 0; ongoing transfer abandoned.

Reset
REQ-034 ap_rst_n low: state IDLE, SDA released, to_host tvalid/tuser/tdata 0, from_host tready 0, rx_overflow 0, tx_underrun 0, counters 0, synchronizers 1.
REQ-035 Reset mid-transfer releases SDA within one cycle asynchronously; after release block waits for next START.

Verification
REQ-036 Write 0xA0,0x12,0x34,STOP, tready=1 -> three ACKs, to_host bytes 0x12(tuser=1),0x34(tuser=0).
REQ-037 Address 0xA2 -> NACK on address, SDA never driven, no to_host output until next START.
REQ-038 Write 0xA0,0x55,0x66 with tready=0 -> 0x55 ACKed and held, 0x66 NACKed, one rx_overflow pulse.
REQ-039 0xA1 read, from_host supplies 0x3C,0x7E, master ACK then NACK -> bus sees 0x3C,0x7E, two tready pulses, WAIT_STOP.
REQ-040 0xA1 read with from_host tvalid=0 -> bus reads 0xFF, one tx_underrun pulse.
REQ-041 ap_rst_n asserted while driving ACK -> SDA released immediately, outputs at reset values, next START handled normally.
